uart8_rx_controller: RTL and testbench
======================================

UART8_RX_CONTROLLER -- requirements
Module: uart8_rx_controller

Interface
REQ-001 Parameter DEPTH, default 4, byte FIFO depth; power of two, 2..16.
REQ-002 Parameter ERR_LIMIT, default 4, consecutive frame errors that force recovery; range 1..15.
REQ-003 clk  input  1  rx sampling clock, 16x baud; the same clock that drives the receiver.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  software enable for reception.
REQ-006 rx_en  output  1  enable driven to the 8-bit receiver.
REQ-007 rx_busy  input  1  receiver frame in progress.
REQ-008 rx_done  input  1  receiver frame complete; held high up to 16 clk.
REQ-009 rx_err  input  1  receiver frame error; held high up to 16 clk.
REQ-010 rx_data  input  8  receiver output byte; valid while rx_done is high.
REQ-011 m_valid  output  1  FIFO head byte available.
REQ-012 m_ready  input  1  consumer accepts the head byte.
REQ-013 m_data  output  8  FIFO head byte.
REQ-014 level  output  5  FIFO occupancy, 0..DEPTH.
REQ-015 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-016 err_count  output  8  saturating count of frame errors.
REQ-017 clear_stats  input  1  single-cycle pulse; clears overrun and err_count.
REQ-018 recovering  output  1  high while in the RECOVER state.

Function
REQ-019 Edge detect: done_rise = rx_done & ~done_q and err_rise = rx_err & ~err_q, where done_q/err_q are registered copies; each receiver pulse is acted on exactly once.
REQ-020 States: OFF, ACTIVE, DRAIN, RECOVER.
REQ-021 rx_en = 1 only in ACTIVE and DRAIN.
REQ-022 OFF -> ACTIVE on the first clk with enable=1.
REQ-023 ACTIVE -> OFF when enable=0 and rx_busy=0.
REQ-024 ACTIVE -> DRAIN when enable=0 and rx_busy=1.
REQ-025 DRAIN -> OFF on done_rise, err_rise, or rx_busy=0; a byte completing during DRAIN is pushed.
REQ-026 ACTIVE -> RECOVER when err_rise brings the consecutive-error counter to ERR_LIMIT.
REQ-027 RECOVER holds rx_en=0 for exactly 16 clk, clears the consecutive-error counter, then goes to ACTIVE if enable=1, else OFF.
REQ-028 Consecutive-error counter (4 bits): +1 on err_rise; cleared on done_rise and on entry to OFF.
REQ-029 Push on done_rise in ACTIVE or DRAIN: write rx_data at the tail; level+1.
REQ-030 Pop when m_valid & m_ready: advance the head; level-1.
REQ-031 m_valid = (level != 0); m_data = entry at head, shown combinationally from storage.
REQ-032 Push and pop in the same cycle: both take effect and level is unchanged, including when level=DEPTH (push accepted) and when level=0 (no pop, push only).
REQ-033 Push with level=DEPTH and no pop: byte dropped, overrun set, storage and level unchanged.
REQ-034 Pointers wrap modulo DEPTH; level never exceeds DEPTH and never goes below 0.
REQ-035 err_count +1 on each err_rise, saturating at 255.
REQ-036 clear_stats: overrun and err_count reset the next cycle; a simultaneous overrun event or err_rise wins (flag set / count = 1).
REQ-037 done_rise or err_rise while in OFF or RECOVER is ignored (no push, no count).
REQ-038 The FIFO contents are retained across OFF/RECOVER; software drains them via m_ready.

Reset
REQ-039 On rst_n=0, immediately: state=OFF, rx_en=0, level=0, pointers=0, m_valid=0, overrun=0, err_count=0, recovering=0, done_q=err_q=0, consecutive-error counter=0.
REQ-040 m_data after reset reads 8'h00 (storage cleared).
REQ-041 Reset asserted mid-frame: the FIFO is emptied, and the first clk after release is in OFF.

Verification
REQ-042 enable=1, receiver delivers 0xA5, 0x3C, m_ready=1 -> m_data 0xA5 then 0x3C, one beat each, level returns to 0, overrun=0.
REQ-043 DEPTH=4, m_ready=0, 5 frames 0x01..0x05 -> level=4, overrun=1, pops yield 0x01..0x04.
REQ-044 level=4, m_ready=1 on the same cycle as done_rise with 0x77 -> level stays 4, overrun=0, 0x77 is the last byte popped.
REQ-045 ERR_LIMIT=4, 4 consecutive errored frames -> err_count=4, recovering=1 and rx_en=0 for 16 clk, then ACTIVE; a good frame afterwards is pushed.
REQ-046 enable dropped during a frame (rx_busy=1) carrying 0x5A -> DRAIN, 0x5A pushed, then OFF with rx_en=0.
REQ-047 err_count=255 plus another error -> stays 255; clear_stats pulse -> err_count=0 and overrun=0 on the next cycle.

Source files
------------

// File: rtl/uart8_rx_controller_if.sv
// Byte stream from the receive FIFO to its consumer (valid/ready handshake).
interface uart8_rx_controller_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart8_rx_controller.sv
// Control wrapper for an 8-bit UART receiver: enable sequencing, error recovery,
// byte FIFO towards the consumer and error/overrun statistics.
module uart8_rx_controller #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic                         rx_en,
  input  logic                         rx_busy,
  input  logic                         rx_done,
  input  logic                         rx_err,
  input  logic [7:0]                   rx_data,
  uart8_rx_controller_if.master        m,
  output logic [4:0]                   level,
  output logic                         overrun,
  output logic [7:0]                   err_count,
  input  logic                         clear_stats,
  output logic                         recovering
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  FULL  = 5'(DEPTH);

  typedef enum logic [1:0] {OFF, ACTIVE, DRAIN, RECOVER} state_t;

  state_t             state_q, state_d;
  logic               done_q, err_q;
  logic [3:0]         rec_cnt;
  logic [3:0]         consec;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [7:0]         mem [DEPTH];

  logic done_rise, err_rise, accept, done_acc, err_acc, limit_hit;
  logic pop, push_ok, overrun_ev;

  assign done_rise = rx_done & ~done_q;
  assign err_rise  = rx_err & ~err_q;
  assign accept    = (state_q == ACTIVE) || (state_q == DRAIN);
  assign done_acc  = done_rise & accept;
  assign err_acc   = err_rise & accept;
  // A frame flagged both done and error counts as good for the streak
  assign limit_hit = err_acc && !done_acc && ((5'(consec) + 5'd1) == 5'(ERR_LIMIT));

  assign rx_en      = accept;
  assign recovering = (state_q == RECOVER);

  assign m.m_valid = (level != 5'd0);
  assign m.m_data  = mem[rd_ptr];

  assign pop        = m.m_valid & m.m_ready;
  assign push_ok    = done_acc & ((level != FULL) | pop);
  assign overrun_ev = done_acc & (level == FULL) & ~pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (enable) state_d = ACTIVE;
      ACTIVE: begin
        if (limit_hit)    state_d = RECOVER;
        else if (!enable) state_d = rx_busy ? DRAIN : OFF;
      end
      DRAIN:   if (done_rise || err_rise || !rx_busy) state_d = OFF;
      RECOVER: if (rec_cnt == 4'd15) state_d = enable ? ACTIVE : OFF;
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rec_cnt <= '0;
      consec  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= rx_done;
      err_q   <= rx_err;
      rec_cnt <= (state_q == RECOVER) ? rec_cnt + 4'd1 : '0;
      if ((state_q == RECOVER) || (state_d == OFF && state_q != OFF))
        consec <= '0;
      else if (done_acc)
        consec <= '0;
      else if (err_acc && consec != 4'hF)
        consec <= consec + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Events in the same cycle as clear_stats take precedence over the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (overrun_ev)       overrun <= 1'b1;
      else if (clear_stats) overrun <= 1'b0;
      if (err_acc)
        err_count <= clear_stats ? 8'd1 :
                     (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
      else if (clear_stats)
        err_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart8_rx_controller.sv
// Directed bench for uart8_rx_controller (DEPTH=4, ERR_LIMIT=4).
module tb_uart8_rx_controller;

  logic       clk = 1'b0;
  logic       rst_n, enable, rx_busy, rx_done, rx_err, clear_stats;
  logic [7:0] rx_data;
  logic       rx_en, overrun, recovering;
  logic [4:0] level;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] popped [$];

  uart8_rx_controller_if bus ();

  uart8_rx_controller #(.DEPTH(4), .ERR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_en(rx_en),
    .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err), .rx_data(rx_data),
    .m(bus), .level(level), .overrun(overrun), .err_count(err_count),
    .clear_stats(clear_stats), .recovering(recovering)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.m_valid && bus.m_ready) popped.push_back(bus.m_data);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    if (bad) rx_err = 1'b1;
    else begin rx_done = 1'b1; rx_data = b; end
    tick(3);
    rx_done = 1'b0;
    rx_err  = 1'b0;
    tick(2);
  endtask

  task automatic err_pulse();
    rx_err = 1'b1;
    tick(1);
    rx_err = 1'b0;
    tick(1);
  endtask

  task automatic wait_recover_end(output int n);
    n = 0;
    while (recovering && n < 40) begin tick(1); n++; end
  endtask

  int  n;
  bit  en_seen;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; rx_busy = 1'b0; rx_done = 1'b0; rx_err = 1'b0;
    rx_data = '0; clear_stats = 1'b0; bus.m_ready = 1'b0;
    #3;
    check("rst_rx_en", rx_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_count", err_count, 0);
    check("rst_recovering", recovering, 0);
    check("rst_m_data", bus.m_data, 8'h00);
    tick(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(1);
    check("enable_rx_en", rx_en, 1);

    // two bytes straight through
    bus.m_ready = 1'b1;
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    tick(3);
    check("pass_beats", popped.size(), 2);
    if (popped.size() == 2) begin
      check("pass_byte0", popped[0], 8'hA5);
      check("pass_byte1", popped[1], 8'h3C);
    end
    check("pass_level", level, 0);
    check("pass_overrun", overrun, 0);

    // overflow with consumer stalled
    bus.m_ready = 1'b0;
    popped.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    check("ovf_level", level, 4);
    check("ovf_overrun", overrun, 1);
    check("ovf_head", bus.m_data, 8'h01);
    bus.m_ready = 1'b1;
    tick(6);
    bus.m_ready = 1'b0;
    check("ovf_pops", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) check("ovf_pop_byte", popped[i], i + 1);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check("clr_overrun", overrun, 0);

    // push and pop together while full
    popped.delete();
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    send_frame(8'h33, 0);
    send_frame(8'h44, 0);
    check("full_level", level, 4);
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0; rx_done = 1'b1; rx_data = 8'h77; bus.m_ready = 1'b1;
    tick(1);
    bus.m_ready = 1'b0;
    check("pp_level", level, 4);
    check("pp_overrun", overrun, 0);
    check("pp_one_pop", popped.size(), 1);
    tick(2);
    rx_done = 1'b0;
    tick(1);
    bus.m_ready = 1'b1;
    tick(6);
    check("pp_total_pops", popped.size(), 5);
    if (popped.size() == 5) check("pp_last_byte", popped[4], 8'h77);
    check("pp_level_end", level, 0);

    // error streak forces recovery
    popped.delete();
    send_frame(8'h00, 1);
    send_frame(8'h00, 1);
    send_frame(8'h00, 1);
    check("streak3_count", err_count, 3);
    check("streak3_not_rec", recovering, 0);
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0; rx_err = 1'b1;
    tick(1);
    check("rec_enter", recovering, 1);
    check("rec_rx_en", rx_en, 0);
    check("rec_err_count", err_count, 4);
    n = 0; en_seen = 1'b0;
    while (recovering && n < 40) begin
      if (rx_en) en_seen = 1'b1;
      tick(1);
      n++;
      if (n == 2) rx_err = 1'b0;
      if (n == 4) begin rx_done = 1'b1; rx_data = 8'hEE; end
      if (n == 6) rx_done = 1'b0;
    end
    check("rec_cycles", n, 16);
    check("rec_en_low", en_seen, 0);
    check("rec_back_active", rx_en, 1);
    send_frame(8'h96, 0);
    tick(3);
    check("rec_good_pops", popped.size(), 1);
    if (popped.size() == 1) check("rec_good_byte", popped[0], 8'h96);

    // enable dropped mid-frame
    popped.delete();
    rx_busy = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    check("drain_rx_en", rx_en, 1);
    tick(2);
    rx_busy = 1'b0; rx_done = 1'b1; rx_data = 8'h5A;
    tick(1);
    check("drain_off", rx_en, 0);
    tick(2);
    rx_done = 1'b0;
    tick(3);
    check("drain_pops", popped.size(), 1);
    if (popped.size() == 1) check("drain_byte", popped[0], 8'h5A);
    send_frame(8'hEE, 1);
    send_frame(8'hEE, 0);
    check("off_err_ignored", err_count, 4);
    check("off_push_ignored", level, 0);

    // saturate err_count: 62 batches of 4 errors from 4 -> 252
    enable = 1'b1;
    tick(1);
    for (int b = 0; b < 62; b++) begin
      repeat (4) err_pulse();
      wait_recover_end(n);
    end
    check("sat_252", err_count, 252);
    check("sat_active", rx_en, 1);
    repeat (3) err_pulse();
    check("sat_255", err_count, 255);
    err_pulse();
    check("sat_hold", err_count, 255);
    check("sat_rec", recovering, 1);
    wait_recover_end(n);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check("clr_err_count", err_count, 0);
    check("clr_overrun2", overrun, 0);
    rx_err = 1'b1; clear_stats = 1'b1;
    tick(1);
    rx_err = 1'b0; clear_stats = 1'b0;
    check("clr_err_wins", err_count, 1);
    tick(1);

    // overrun event wins over clear
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0);
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0; rx_done = 1'b1; rx_data = 8'h55; clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check("clr_ovr_wins", overrun, 1);
    check("clr_ovr_level", level, 4);
    tick(2);
    rx_done = 1'b0;

    // asynchronous reset mid-frame
    rx_busy = 1'b1;
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_m_valid", bus.m_valid, 0);
    check("arst_rx_en", rx_en, 0);
    check("arst_m_data", bus.m_data, 8'h00);
    rx_busy = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("arst_first_off", rx_en, 0);
    tick(1);
    check("arst_then_active", rx_en, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
